// File: rtl/jk_excitation_counter.sv
// ---------------------------------------------------------------------------
// jk_excitation_counter
//
// Modulo-MODULUS up/down counter whose state register is a bank of JK
// flip-flop bits. The desired next state is computed first, turned into
// per-bit J/K excitation, and the register then applies exact JK semantics
// bit by bit. Q after an edge always equals the next state seen before it.
//
// Parameters:
//   WIDTH    - counter width in bits
//   MODULUS  - count range 0..MODULUS-1, legal 2..2**WIDTH
//
// Ports:
//   CLK      - clock, rising edge
//   RESET    - asynchronous reset, active-high (Q=0, LOAD_ERR=0)
//   EN       - count enable
//   UP       - direction, 1 = increment, 0 = decrement
//   LOAD     - synchronous parallel load, priority over EN
//   D        - load value
//   Q        - current count (registered)
//   J, K     - per-bit excitation for the next edge (combinational)
//   TC       - terminal count: the coming edge wraps (combinational)
//   LOAD_ERR - registered, last load value was >= MODULUS
//
// Build option:
//   JK_TOGGLE_STYLE_EN - when defined, excitation is toggle style
//                        (J=K=Q^N per bit); otherwise set/reset style
//                        (J=~Q&N, K=Q&~N). Q, TC and LOAD_ERR are identical.
// ---------------------------------------------------------------------------
module jk_excitation_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             TC,
    output logic             LOAD_ERR
);

    // MODULUS may equal 2**WIDTH, so the range compare needs one extra bit.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_q;
    logic             d_ok;

    assign d_ok = ({1'b0, D} < MOD_W);

    // Wrap is by explicit compare; an out-of-range Q is treated as >= MODULUS.
    always_comb begin
        next_q = Q;
        if (LOAD) begin
            next_q = d_ok ? D : '0;
        end else if (EN) begin
            if (UP) begin
                next_q = (Q >= MAX_Q) ? '0 : Q + WIDTH'(1);
            end else begin
                next_q = ((Q == '0) || (Q > MAX_Q)) ? MAX_Q : Q - WIDTH'(1);
            end
        end
    end

`ifdef JK_TOGGLE_STYLE_EN
    assign J = Q ^ next_q;
    assign K = Q ^ next_q;
`else
    assign J = ~Q & next_q;
    assign K = Q & ~next_q;
`endif

    assign TC = EN & ~LOAD & (UP ? (Q == MAX_Q) : (Q == '0));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q        <= '0;
            LOAD_ERR <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case ({J[i], K[i]})
                    2'b11:   Q[i] <= ~Q[i];
                    2'b01:   Q[i] <= 1'b0;
                    2'b10:   Q[i] <= 1'b1;
                    default: Q[i] <= Q[i];
                endcase
            end
            if (LOAD) begin
                LOAD_ERR <= ~d_ok;
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_excitation_counter
//
// Directed self-checking bench for jk_excitation_counter (WIDTH=4,
// MODULUS=10). Expected J/K values switch with JK_TOGGLE_STYLE_EN so the
// same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_jk_excitation_counter;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic       UP;
    logic       LOAD;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] J;
    logic [3:0] K;
    logic       TC;
    logic       LOAD_ERR;

    int checks;
    int errors;

    jk_excitation_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .UP       (UP),
        .LOAD     (LOAD),
        .D        (D),
        .Q        (Q),
        .J        (J),
        .K        (K),
        .TC       (TC),
        .LOAD_ERR (LOAD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Load a value with all other controls idle.
    task automatic do_load(input logic [3:0] val);
        @(negedge CLK);
        LOAD = 1'b1;
        EN   = 1'b0;
        D    = val;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        EN    = 1'b0;
        UP    = 1'b1;
        LOAD  = 1'b0;
        D     = 4'd0;
        #2;
        checks++;
        if (Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_q: got %0d expected 0", Q);
        end
        checks++;
        if (LOAD_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_err: got %b expected 0", LOAD_ERR);
        end
        checks++;
        if (J !== 4'b0000 || K !== 4'b0000 || TC !== 1'b0) begin
            errors++;
            $display("FAIL reset_jk_tc: got J=%b K=%b TC=%b expected 0000 0000 0", J, K, TC);
        end
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        checks++;
        if (Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle_q: got %0d expected 0", Q);
        end
    endtask

    task automatic test_up_count();
        logic [3:0] seq [11];
        logic [3:0] cur;
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
        do_load(4'd0);
        @(negedge CLK);
        EN = 1'b1;
        UP = 1'b1;
        #1;
        cur = 4'd0;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (TC !== (cur == 4'd9)) begin
                errors++;
                $display("FAIL up_tc[%0d]: Q=%0d got TC=%b expected %b", i, cur, TC, cur == 4'd9);
            end
            if (cur == 4'd9) begin
                checks++;
`ifdef JK_TOGGLE_STYLE_EN
                if (J !== 4'b1001 || K !== 4'b1001) begin
                    errors++;
                    $display("FAIL up_jk_at9: got J=%b K=%b expected 1001 1001", J, K);
                end
`else
                if (J !== 4'b0000 || K !== 4'b1001) begin
                    errors++;
                    $display("FAIL up_jk_at9: got J=%b K=%b expected 0000 1001", J, K);
                end
`endif
            end
            if (cur == 4'd7) begin
                checks++;
`ifdef JK_TOGGLE_STYLE_EN
                if (J !== 4'b1111 || K !== 4'b1111) begin
                    errors++;
                    $display("FAIL up_jk_at7: got J=%b K=%b expected 1111 1111", J, K);
                end
`else
                if (J !== 4'b1000 || K !== 4'b0111) begin
                    errors++;
                    $display("FAIL up_jk_at7: got J=%b K=%b expected 1000 0111", J, K);
                end
`endif
            end
            tick();
            checks++;
            if (Q !== seq[i]) begin
                errors++;
                $display("FAIL up_q[%0d]: got %0d expected %0d", i, Q, seq[i]);
            end
            cur = seq[i];
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    task automatic test_down_wrap();
        do_load(4'd0);
        @(negedge CLK);
        EN = 1'b1;
        UP = 1'b0;
        #1;
        checks++;
        if (TC !== 1'b1) begin
            errors++;
            $display("FAIL down_tc_at0: got %b expected 1", TC);
        end
        checks++;
`ifdef JK_TOGGLE_STYLE_EN
        if (J !== 4'b1001 || K !== 4'b1001) begin
            errors++;
            $display("FAIL down_jk_at0: got J=%b K=%b expected 1001 1001", J, K);
        end
`else
        if (J !== 4'b1001 || K !== 4'b0000) begin
            errors++;
            $display("FAIL down_jk_at0: got J=%b K=%b expected 1001 0000", J, K);
        end
`endif
        tick();
        checks++;
        if (Q !== 4'd9) begin
            errors++;
            $display("FAIL down_wrap_q: got %0d expected 9", Q);
        end
        checks++;
        if (TC !== 1'b0) begin
            errors++;
            $display("FAIL down_tc_at9: got %b expected 0", TC);
        end
        checks++;
`ifdef JK_TOGGLE_STYLE_EN
        if (J !== 4'b0001 || K !== 4'b0001) begin
            errors++;
            $display("FAIL down_jk_at9: got J=%b K=%b expected 0001 0001", J, K);
        end
`else
        if (J !== 4'b0000 || K !== 4'b0001) begin
            errors++;
            $display("FAIL down_jk_at9: got J=%b K=%b expected 0000 0001", J, K);
        end
`endif
        tick();
        checks++;
        if (Q !== 4'd8) begin
            errors++;
            $display("FAIL down_q_after9: got %0d expected 8", Q);
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    task automatic test_load();
        logic [3:0] dv  [4];
        logic [3:0] eq  [4];
        logic       eer [4];
        @(negedge CLK);
        LOAD = 1'b1;
        EN   = 1'b1;
        UP   = 1'b1;
        D    = 4'd7;
        #1;
        checks++;
        if (TC !== 1'b0) begin
            errors++;
            $display("FAIL load_tc_masked: got %b expected 0", TC);
        end
        tick();
        checks++;
        if (Q !== 4'd7 || LOAD_ERR !== 1'b0) begin
            errors++;
            $display("FAIL load_7: got Q=%0d ERR=%b expected 7 0", Q, LOAD_ERR);
        end
        @(negedge CLK);
        EN = 1'b0;
        D  = 4'd12;
        #1;
        checks++;
`ifdef JK_TOGGLE_STYLE_EN
        if (J !== 4'b0111 || K !== 4'b0111) begin
            errors++;
            $display("FAIL load_12_jk: got J=%b K=%b expected 0111 0111", J, K);
        end
`else
        if (J !== 4'b0000 || K !== 4'b0111) begin
            errors++;
            $display("FAIL load_12_jk: got J=%b K=%b expected 0000 0111", J, K);
        end
`endif
        tick();
        checks++;
        if (Q !== 4'd0 || LOAD_ERR !== 1'b1) begin
            errors++;
            $display("FAIL load_12: got Q=%0d ERR=%b expected 0 1", Q, LOAD_ERR);
        end
        @(negedge CLK);
        LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (J !== 4'b0000 || K !== 4'b0000) begin
                errors++;
                $display("FAIL load_idle_jk[%0d]: got J=%b K=%b expected 0000 0000", i, J, K);
            end
            tick();
            checks++;
            if (Q !== 4'd0 || LOAD_ERR !== 1'b1) begin
                errors++;
                $display("FAIL load_idle_q[%0d]: got Q=%0d ERR=%b expected 0 1", i, Q, LOAD_ERR);
            end
        end
        // Range boundaries around MODULUS.
        dv  = '{4'd9, 4'd10, 4'd15, 4'd3};
        eq  = '{4'd9, 4'd0,  4'd0,  4'd3};
        eer = '{1'b0, 1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 4; i++) begin
            do_load(dv[i]);
            checks++;
            if (Q !== eq[i] || LOAD_ERR !== eer[i]) begin
                errors++;
                $display("FAIL load_range[D=%0d]: got Q=%0d ERR=%b expected %0d %b",
                         dv[i], Q, LOAD_ERR, eq[i], eer[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_load(4'd5);
        @(negedge CLK);
        EN   = 1'b0;
        LOAD = 1'b0;
        UP   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (J !== 4'b0000 || K !== 4'b0000 || TC !== 1'b0) begin
                errors++;
                $display("FAIL hold_jk_tc[%0d]: got J=%b K=%b TC=%b expected 0000 0000 0", i, J, K, TC);
            end
            tick();
            checks++;
            if (Q !== 4'd5) begin
                errors++;
                $display("FAIL hold_q[%0d]: got %0d expected 5", i, Q);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        do_load(4'd12);
        do_load(4'd0);
        // LOAD_ERR was cleared by loading 0; set it again so reset has work to do.
        do_load(4'd13);
        @(negedge CLK);
        EN = 1'b1;
        UP = 1'b1;
        repeat (6) tick();
        checks++;
        if (Q !== 4'd6 || LOAD_ERR !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got Q=%0d ERR=%b expected 6 1", Q, LOAD_ERR);
        end
        @(negedge CLK);
        LOAD = 1'b1;
        D    = 4'd3;
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (Q !== 4'd0 || LOAD_ERR !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got Q=%0d ERR=%b expected 0 0", Q, LOAD_ERR);
        end
        tick();
        checks++;
        if (Q !== 4'd0) begin
            errors++;
            $display("FAIL midreset_wins: got Q=%0d expected 0", Q);
        end
        @(negedge CLK);
        RESET = 1'b0;
        LOAD  = 1'b0;
        EN    = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [4];
        logic       tcs [4];
        seq = '{4'd1, 4'd0, 4'd9, 4'd8};
        tcs = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_load(4'd2);
        @(negedge CLK);
        EN = 1'b1;
        UP = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (TC !== tcs[i]) begin
                errors++;
                $display("FAIL b2b_tc[%0d]: got %b expected %b", i, TC, tcs[i]);
            end
            tick();
            checks++;
            if (Q !== seq[i]) begin
                errors++;
                $display("FAIL b2b_q[%0d]: got %0d expected %0d", i, Q, seq[i]);
            end
        end
        @(negedge CLK);
        EN = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load();
        test_hold();
        test_reset_mid_count();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/jk_excitation_counter.md
Name: jk_excitation_counter

Overview:
- Modulo-N up/down counter whose state register is a bank of JK flip-flop bits, driven from an excitation-table encoder.
- Complements the single JK flip-flop: that cell consumes J/K; this block produces J/K from the desired next state, then applies JK semantics per bit.
- Exposes the per-bit J/K vectors so the team can verify excitation logic against counter sequence in sims and lab exercises.

Parameters:
- WIDTH, 4, counter/state width in bits
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous reset, active-high
- EN  input  1  count enable
- UP  input  1  direction: 1 = increment, 0 = decrement
- LOAD  input  1  synchronous parallel load, priority over EN
- D  input  WIDTH  load value
- Q  output  WIDTH  current count (registered)
- J  output  WIDTH  per-bit J excitation for the next edge (combinational)
- K  output  WIDTH  per-bit K excitation for the next edge (combinational)
- TC  output  1  terminal count (combinational)
- LOAD_ERR  output  1  registered flag: last load value was out of range

Behaviour:
- Reset (async, RESET=1): Q=0, LOAD_ERR=0 immediately, independent of CLK. J/K/TC follow the combinational rules from Q=0. Reset asserted mid-count wins over any LOAD/EN in the same cycle.
- Next-state N (combinational), priority order:
  - LOAD=1, D<MODULUS: N=D.
  - LOAD=1, D>=MODULUS: N=0.
  - EN=1, UP=1: N = (Q==MODULUS-1) ? 0 : Q+1.
  - EN=1, UP=0: N = (Q==0) ? MODULUS-1 : Q-1.
  - Otherwise: N=Q (hold).
- Excitation, default set/reset style, per bit i:
  - J[i] = ~Q[i] & N[i]
  - K[i] = Q[i] & ~N[i]
  - Hold produces J=K=0 on every bit.
- State update per bit at the rising edge, exact JK semantics:
  - J&K: toggle.
  - K only: 0.
  - J only: 1.
  - Neither: hold.
  - Invariant: Q after the edge == N before the edge, in every mode.
- Latency: one cycle from LOAD/EN to the new Q.
- TC = EN & ~LOAD & (UP ? Q==MODULUS-1 : Q==0). TC is high during the cycle in which the wrap edge will occur.
- LOAD_ERR is updated only on edges where LOAD=1:
  - Set to 1 when D>=MODULUS, cleared to 0 when D<MODULUS.
  - Holds its value otherwise.
- Arithmetic is WIDTH bits; wrap is by explicit compare, never by natural overflow, so a non-power-of-two MODULUS wraps correctly.
- If Q is out of range (only reachable via X or forced state), treat it as Q>=MODULUS:
  - UP: next N=0.
  - DOWN: next N=MODULUS-1.

Optional Feature:
- Macro: JK_TOGGLE_STYLE_EN.
- Defined: excitation uses toggle style, J[i]=K[i]=Q[i]^N[i]. Every changing bit toggles; hold gives J=K=0.
- Not defined: set/reset style as above, where J and K are never both 1.
- Q sequence, TC and LOAD_ERR are identical in both builds. Only the J/K outputs differ.

Test Plan:
- Reset mid-count: count to Q=6, assert RESET between edges -> Q=0 and LOAD_ERR=0 immediately, before next CLK edge.
- Up count, defaults (WIDTH=4, MODULUS=10): EN=1, UP=1 for 11 edges from 0 -> Q = 1..9, 0, 1.
  - TC=1 only while Q=9.
  - At Q=9: J=0000, K=1001.
- Down wrap: Q=0, EN=1, UP=0 -> TC=1, J=1001, K=0000; next Q=9.
- Load priority and range:
  - LOAD=1, D=7, EN=1 -> Q=7, LOAD_ERR=0.
  - Then LOAD=1, D=12 -> Q=0, LOAD_ERR=1.
  - Then EN=0 for 3 edges -> Q=0 held, J=K=0, LOAD_ERR stays 1.
- Hold: EN=0, LOAD=0 at Q=5 -> J=K=0000, Q stays 5 across 4 edges, TC=0.
- Build with JK_TOGGLE_STYLE_EN, Q=7, UP count -> J=K=1111; next Q=8. Full 0..9 sequence matches the default build.
